// File: rtl/bft_pkg.sv
// bft_pkg: shared definitions for the BFT leaf transmitter.
//   - Bit positions of the fields in a 49-bit BFT packet
//     ([48] valid, [47:44] leaf, [43:40] port, [39:33] seq addr,
//     [32] ctrl, [31:0] payload).
//   - Transmitter state encoding.
//   - Receiver buffer depth, which is also the maximum credit count.
package bft_pkg;

  localparam int unsigned VALID_BIT = 48;
  localparam int unsigned LEAF_MSB  = 47;
  localparam int unsigned LEAF_LSB  = 44;
  localparam int unsigned PORT_MSB  = 43;
  localparam int unsigned PORT_LSB  = 40;
  localparam int unsigned ADDR_MSB  = 39;
  localparam int unsigned ADDR_LSB  = 33;
  localparam int unsigned CTRL_BIT  = 32;

  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned CREDIT_MAX = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/bft_credit_counter.sv
// bft_credit_counter: saturating up/down credit counter.
// Ports:
//   clk          in   clock
//   reset        in   asynchronous active-low reset (count -> MAX_VAL)
//   i_inc        in   credits returned this cycle
//   i_dec        in   one credit consumed this cycle
//   o_count      out  registered credit count
//   o_count_next out  count after this cycle's update (for the FSM)
module bft_credit_counter
  import bft_pkg::*;
#(
  parameter int unsigned CNT_W   = ADDR_W + 1,
  parameter int unsigned MAX_VAL = CREDIT_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_count_next
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W:0]   w_sum;

  // One extra bit holds count + inc before saturation. The sum never goes
  // negative because the consumer is never granted a word at zero credits.
  assign w_sum = {1'b0, r_count} + {1'b0, i_inc} - {{CNT_W{1'b0}}, i_dec};

  assign o_count_next = (w_sum > (CNT_W+1)'(MAX_VAL)) ? CNT_W'(MAX_VAL)
                                                       : w_sum[CNT_W-1:0];
  assign o_count      = r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_count <= CNT_W'(MAX_VAL);
    else        r_count <= o_count_next;
  end

endmodule

// File: rtl/bft_stream_tx.sv
// bft_stream_tx: BFT leaf transmitter. Packs 32-bit producer words into
// 49-bit data packets for a fixed destination leaf/port, paced by credits
// returned from the receiving leaf.
// Optional feature macro: BFT_TX_RESEND_EN (keeps the last data packet and
// re-emits it one cycle after a resend pulse).
// Ports:
//   clk          in   clock
//   reset        in   asynchronous active-low reset
//   ap_start     in   level, enables transmission
//   din_user     in   producer word
//   vld_user2tx  in   producer word valid
//   ack_tx2user  out  word accepted this cycle
//   dout_tx2bft  out  packet to BFT (all zero when no packet)
//   din_bft2tx   in   packet from BFT carrying credit returns
//   resend       in   resend request pulse
//   credits      out  current credit count
//   busy         out  state != IDLE
module bft_stream_tx
  import bft_pkg::*;
#(
  parameter int unsigned PACKET_BITS   = 49,
  parameter int unsigned PAYLOAD_BITS  = 32,
  parameter int unsigned NUM_LEAF_BITS = 4,
  parameter int unsigned NUM_PORT_BITS = 4,
  parameter int unsigned NUM_ADDR_BITS = 7,
  parameter int unsigned DEST_LEAF     = 2,
  parameter int unsigned DEST_PORT     = 1,
  parameter int unsigned SELF_LEAF     = 1,
  parameter int unsigned SELF_PORT     = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ap_start,
  input  logic [PAYLOAD_BITS-1:0]  din_user,
  input  logic                     vld_user2tx,
  output logic                     ack_tx2user,
  output logic [PACKET_BITS-1:0]   dout_tx2bft,
  input  logic [PACKET_BITS-1:0]   din_bft2tx,
  input  logic                     resend,
  output logic [NUM_ADDR_BITS:0]   credits,
  output logic                     busy
);

  localparam int unsigned CW = NUM_ADDR_BITS + 1;

  tx_state_e                r_state, w_state_next;
  logic [NUM_ADDR_BITS-1:0] r_seq;
  logic [PACKET_BITS-1:0]   r_dout;
  logic [PACKET_BITS-1:0]   w_data_pkt;
  logic [PACKET_BITS-1:0]   w_resend_pkt;
  logic                     w_resend_slot;
  logic                     w_xfer;
  logic                     w_credit_hit;
  logic [CW-1:0]            w_credit_inc;
  logic [CW-1:0]            w_credits;
  logic [CW-1:0]            w_credits_next;
  logic                     w_unused;

  assign ack_tx2user = vld_user2tx & (r_state == ACTIVE) & (w_credits != '0)
                     & ~w_resend_slot;
  assign w_xfer      = ack_tx2user;

  assign w_data_pkt = {1'b1, NUM_LEAF_BITS'(DEST_LEAF), NUM_PORT_BITS'(DEST_PORT),
                       r_seq, 1'b0, din_user};

  // Credit returns are accepted in every state, including IDLE.
  assign w_credit_hit = din_bft2tx[VALID_BIT] & din_bft2tx[CTRL_BIT]
                      & (din_bft2tx[LEAF_MSB:LEAF_LSB] == NUM_LEAF_BITS'(SELF_LEAF))
                      & (din_bft2tx[PORT_MSB:PORT_LSB] == NUM_PORT_BITS'(SELF_PORT));
  assign w_credit_inc = w_credit_hit ? din_bft2tx[CW-1:0] : '0;

  bft_credit_counter #(
    .CNT_W   (CW),
    .MAX_VAL (1 << NUM_ADDR_BITS)
  ) u_credit_counter (
    .clk          (clk),
    .reset        (reset),
    .i_inc        (w_credit_inc),
    .i_dec        (w_xfer),
    .o_count      (w_credits),
    .o_count_next (w_credits_next)
  );

`ifdef BFT_TX_RESEND_EN
  logic [PACKET_BITS-1:0] r_held;
  logic                   r_have_pkt;

  // A resend before the first data packet has nothing to replay.
  assign w_resend_slot = resend & r_have_pkt;
  assign w_resend_pkt  = r_held;
  assign w_unused      = ^{din_bft2tx[ADDR_MSB:ADDR_LSB],
                           din_bft2tx[PAYLOAD_BITS-1:CW]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_held     <= '0;
      r_have_pkt <= 1'b0;
    end else if (w_xfer) begin
      r_held     <= w_data_pkt;
      r_have_pkt <= 1'b1;
    end
  end
`else
  assign w_resend_slot = 1'b0;
  assign w_resend_pkt  = '0;
  assign w_unused      = ^{din_bft2tx[ADDR_MSB:ADDR_LSB],
                           din_bft2tx[PAYLOAD_BITS-1:CW], resend};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (ap_start) w_state_next = ACTIVE;
      ACTIVE:  if (!ap_start)                 w_state_next = IDLE;
               else if (w_credits_next == '0) w_state_next = STALL;
      STALL:   if (!ap_start)                 w_state_next = IDLE;
               else if (w_credits_next != '0) w_state_next = ACTIVE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output stage: a packet is valid for exactly the cycle after its transfer
  // (or after a resend pulse); ack is blocked during the pulse so the two
  // never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout <= '0;
      r_seq  <= '0;
    end else begin
      if (w_xfer)             r_dout <= w_data_pkt;
      else if (w_resend_slot) r_dout <= w_resend_pkt;
      else                    r_dout <= '0;
      if (w_xfer) r_seq <= r_seq + 1'b1;
    end
  end

  assign dout_tx2bft = r_dout;
  assign credits     = w_credits;
  assign busy        = (r_state != IDLE);

endmodule
